psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream consumer of the fusion unit's registered 18-bit partial sum (psum_fwd).
- Accumulates a programmed number of psum beats into a wide result, with optional per-beat left shift for temporally composed wide operands.
- Handles both fused mode (one 18-bit sum) and split-column mode (two independent 9-bit column sums).
- Emits each finished result on a valid/ready output toward the output buffer.

Parameters:
- PSUM_W, 18: input partial-sum width; fixed at 2 x 9-bit columns.
- ACC_W, 32: accumulator and result width; must be even, since each split lane is ACC_W/2.
- CNT_W, 8: width of the beat counter and acc_len.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: psum_in beat valid.
- in_ready, output, 1: beat accepted when in_valid & in_ready.
- psum_in, input, PSUM_W: fusion unit psum_fwd.
- in_shift, input, 3: left-shift amount applied to this beat, 0..7.
- sign, input, 1: 1 = sign-extend psum, 0 = zero-extend.
- split_column, input, 1: 1 = two lanes, col1 = psum_in[8:0], col2 = psum_in[17:9].
- acc_len, input, CNT_W: number of beats per result; 0 is treated as 1.
- clear, input, 1: synchronous abort of the partial accumulation.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_data, output, ACC_W: result; in split mode {lane2, lane1}, each ACC_W/2 bits.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, accumulator=0, beat count=0, state IDLE. Reset mid-group discards everything.
- States:
  - IDLE: no partial sum. First accepted beat goes to ACCUM, or straight back to IDLE with a result if the effective length is 1.
  - ACCUM: partial sum held. On the last beat, go to IDLE.
- Config latch: sign, split_column and acc_len are sampled on the first beat of a group and held until the group ends. Changes mid-group are ignored.
- in_ready = !clear && (!out_valid || out_ready). The output register is the only buffer, so a result can be replaced in the same cycle it is consumed.
- Per-beat term construction:
  - Fused mode: ext(psum_in, PSUM_W to ACC_W) << in_shift.
  - Split mode: ext each 9-bit column to ACC_W/2, then << in_shift, per lane.
  - ext is sign- or zero-extension according to the latched sign.
  - All adds wrap modulo 2^ACC_W (fused) or 2^(ACC_W/2) per lane. No carry between lanes. No saturation.
- Counting: count increments per accepted beat. The last beat is count == eff_len-1, where eff_len = (acc_len==0) ? 1 : acc_len.
- On the last beat:
  - out_data <= acc + term; out_valid <= 1 on the next edge (latency 1 cycle after the last beat).
  - acc <= 0, count <= 0.
- Throughput: 1 beat/cycle with no bubble between groups while out_ready stays high.
- Output handshake:
  - out_valid stays high and out_data stays stable until out_valid & out_ready.
  - If a new result completes in the same cycle that the old one is taken, out_valid stays 1 with the new data.
  - If out_ready is low while out_valid is high, in_ready=0 and the partial group stalls with its state held.
- clear: acc=0, count=0, state IDLE; any beat presented that cycle is not accepted. A pending out_valid/out_data is unaffected.
- Boundary cases:
  - Count reaching 2^CNT_W-1 with acc_len=0xFF terminates normally.
  - in_valid low mid-group simply pauses accumulation; there is no timeout.

Decomposition:
- Shared package: PSUM_W, COL_W=9, the shift-width constant, and the state enum {IDLE, ACCUM}.
- One sub-module, psum_extend_shift: combinational term builder (sign/zero-extend, split, shift).
- The FSM, counter and output register stay in the top.

Test Plan:
- Fused unsigned, acc_len=3, shift 0, beats 5, 10, 20 -> out_data=35, out_valid one cycle after the third beat.
- Fused signed, acc_len=4, four beats of 18'h3FFFF -> out_data=32'hFFFFFFFC.
- Split signed, acc_len=2, two beats of {9'd3, 9'h1FF} -> out_data={16'd6, 16'hFFFE}. Lane-1 wrap must not carry into lane 2.
- Shift, acc_len=2: beat 3 with shift 0, then beat 1 with shift 2 -> out_data=7. acc_len=0 with a single beat 9 -> out_data=9.
- Backpressure: hold out_ready=0 after a result -> in_ready=0 and the next group stalls. out_ready=1 -> result popped, then the next group proceeds back-to-back, producing results on consecutive groups with no lost or duplicated beats.
- clear after 2 of 4 beats, then 4 fresh beats of 1 -> out_data=4. Assert rst_n mid-group -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared constants and types for the partial-sum accumulator.
package psum_accumulator_pkg;

  // Fusion-unit partial sum: two 9-bit columns side by side.
  localparam int PSUM_W  = 18;
  localparam int COL_W   = 9;
  // Per-beat left shift, 0..7.
  localparam int SHIFT_W = 3;

  // IDLE: no partial sum held. ACCUM: a group is in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/psum_extend_shift.sv
// Combinational term builder: widens one psum beat to the accumulator
// width (fused) or to two independent half-width lanes (split), then
// applies the per-beat left shift.
module psum_extend_shift
  import psum_accumulator_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [PSUM_W-1:0]  psum,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sign,
  input  logic               split_column,
  output logic [ACC_W-1:0]   term
);

  localparam int LANE_W = ACC_W / 2;

  logic [ACC_W-1:0]  fused_ext;
  logic [LANE_W-1:0] col1_ext;
  logic [LANE_W-1:0] col2_ext;
  logic [LANE_W-1:0] col1_shifted;
  logic [LANE_W-1:0] col2_shifted;

  // Extend, then shift inside the lane so bits shifted out of one lane
  // are dropped rather than leaking into the neighbouring lane.
  always_comb begin
    fused_ext    = {{(ACC_W - PSUM_W){sign & psum[PSUM_W-1]}}, psum};
    col1_ext     = {{(LANE_W - COL_W){sign & psum[COL_W-1]}}, psum[COL_W-1:0]};
    col2_ext     = {{(LANE_W - COL_W){sign & psum[PSUM_W-1]}}, psum[PSUM_W-1:COL_W]};
    col1_shifted = col1_ext << shift;
    col2_shifted = col2_ext << shift;
    if (split_column) begin
      term = {col2_shifted, col1_shifted};
    end else begin
      term = fused_ext << shift;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a programmed number of psum beats into one wide result and
// presents it on a valid/ready output. The output register is the only
// result buffer; a new result may overwrite it in the cycle it is taken.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PSUM_W-1:0]  psum_in,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               sign,
  input  logic               split_column,
  input  logic [CNT_W-1:0]   acc_len,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data
);

  localparam int LANE_W = ACC_W / 2;

  state_t            state;
  state_t            state_next;

  // Group configuration captured on the first beat.
  logic              cfg_sign;
  logic              cfg_split;
  logic [CNT_W-1:0]  cfg_len;

  logic [CNT_W-1:0]  count;
  logic [ACC_W-1:0]  acc;

  logic              eff_sign;
  logic              eff_split;
  logic [CNT_W-1:0]  len_sel;
  logic [CNT_W-1:0]  last_idx;
  logic              accept;
  logic              last_beat;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  sum;

  // A beat may enter only when the output slot is free or being freed.
  assign in_ready  = !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == last_idx);

  // First beat of a group uses the live config; later beats the latched one.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    eff_sign  = cfg_sign;
    eff_split = cfg_split;
    len_sel   = cfg_len;
    if (state == IDLE) begin
      eff_sign  = sign;
      eff_split = split_column;
      len_sel   = acc_len;
    end
    // acc_len of 0 behaves as a single-beat group.
    last_idx = (len_sel == '0) ? '0 : len_sel - 1'b1;
  end

  psum_extend_shift #(
    .ACC_W (ACC_W)
  ) u_extend_shift (
    .psum         (psum_in),
    .shift        (in_shift),
    .sign         (eff_sign),
    .split_column (eff_split),
    .term         (term)
  );

  // Fused mode adds full width; split mode adds each lane with no carry across.
  always_comb begin
    if (eff_split) begin
      sum = {acc[ACC_W-1:LANE_W] + term[ACC_W-1:LANE_W],
             acc[LANE_W-1:0]     + term[LANE_W-1:0]};
    end else begin
      sum = acc + term;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state <= state_next;
    end
  end

  // Next state: clear aborts the group; the last beat closes it.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = last_beat ? IDLE : ACCUM;
    end
  end

  // Accumulator, beat counter and config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: config registers are reset too, so nothing depends on X before the first group.
      acc       <= '0;
      count     <= '0;
      cfg_sign  <= 1'b0;
      cfg_split <= 1'b0;
      cfg_len   <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        cfg_sign  <= sign;
        cfg_split <= split_column;
        cfg_len   <= acc_len;
      end
      if (last_beat) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + 1'b1;
      end
    end
  end

  // Output register: load on the last beat, drop valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && last_beat) begin
      out_valid <= 1'b1;
      out_data  <= sum;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: directed scenarios plus a
// randomized back-to-back run scored against an arithmetic reference model.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] psum_in;
  logic [2:0]  in_shift;
  logic        sign;
  logic        split_column;
  logic [7:0]  acc_len;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  bit          mon_en = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  psum_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .psum_in      (psum_in),
    .in_shift     (in_shift),
    .sign         (sign),
    .split_column (split_column),
    .acc_len      (acc_len),
    .clear        (clear),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  // Records every result that will be handshaken on the coming rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && rst_n && out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  // Signed or unsigned value of a w-bit field.
  function automatic longint sval(input longint v, input int w, input bit s);
    if (s && v[w-1]) return v - (longint'(1) << w);
    return v;
  endfunction

  // Reference: sum of extended, shifted beats, wrapped to 32 bits or per 16-bit lane.
  function automatic logic [31:0] model_result(input logic [17:0] ps[$], input logic [2:0] sh[$],
                                               input bit sgn, input bit spl);
    longint total = 0;
    longint lo = 0;
    longint hi = 0;
    logic [31:0] r;
    foreach (ps[i]) begin
      total += sval(longint'(ps[i]), 18, sgn) * (longint'(1) << sh[i]);
      lo    += sval(longint'(ps[i][8:0]), 9, sgn) * (longint'(1) << sh[i]);
      hi    += sval(longint'(ps[i][17:9]), 9, sgn) * (longint'(1) << sh[i]);
    end
    if (spl) r = {hi[15:0], lo[15:0]};
    else     r = total[31:0];
    return r;
  endfunction

  // Presents one beat and returns at the falling edge after it is accepted.
  task automatic send_beat(input logic [17:0] p, input logic [2:0] sh, input logic sg,
                           input logic sp, input logic [7:0] len);
    in_valid = 1'b1; psum_in = p; in_shift = sh; sign = sg; split_column = sp; acc_len = len;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL send_beat: beat %0h not accepted, in_ready=%0b required 1 within 200 cycles", p, in_ready);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; psum_in = '0; in_shift = '0; sign = 1'b0;
    split_column = 1'b0; acc_len = '0; clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fused_unsigned();
    send_beat(18'd5, 3'd0, 1'b0, 1'b0, 8'd3);
    // Mid-group config changes must be ignored.
    send_beat(18'd10, 3'd0, 1'b1, 1'b1, 8'd1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fused_unsigned_early: out_valid got %0b want 0", out_valid); end
    send_beat(18'd20, 3'd0, 1'b1, 1'b1, 8'd1);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fused_unsigned_latency: out_valid got %0b want 1", out_valid); end
    checks++; if (out_data !== 32'd35) begin errors++; $display("FAIL fused_unsigned_data: got %0h want %0h", out_data, 32'd35); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fused_unsigned_pop: out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_fused_signed();
    repeat (4) send_beat(18'h3FFFF, 3'd0, 1'b1, 1'b0, 8'd4);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFFC) begin errors++;
      $display("FAIL fused_signed: valid=%0b data=%0h want valid=1 data=fffffffc", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_split_signed();
    repeat (2) send_beat({9'd3, 9'h1FF}, 3'd0, 1'b1, 1'b1, 8'd2);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== {16'd6, 16'hFFFE}) begin errors++;
      $display("FAIL split_signed: valid=%0b data=%0h want valid=1 data=0006fffe", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_shift();
    send_beat(18'd3, 3'd0, 1'b0, 1'b0, 8'd2);
    send_beat(18'd1, 3'd2, 1'b0, 1'b0, 8'd2);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin errors++;
      $display("FAIL shift: valid=%0b data=%0h want valid=1 data=7", out_valid, out_data); end
    @(negedge clk);
    send_beat(18'd9, 3'd0, 1'b0, 1'b0, 8'd0);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd9) begin errors++;
      $display("FAIL len_zero: valid=%0b data=%0h want valid=1 data=9", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(18'd7, 3'd0, 1'b0, 1'b0, 8'd1);
    in_valid = 1'b1; psum_in = 18'd5; in_shift = 3'd0; sign = 1'b0; split_column = 1'b0; acc_len = 8'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin errors++;
        $display("FAIL bp_hold: valid=%0b data=%0h want valid=1 data=7", out_valid, out_data); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready got %0b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_popped: out_valid got %0b want 0", out_valid); end
    send_beat(18'd6, 3'd0, 1'b1, 1'b1, 8'd9);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd11) begin errors++;
      $display("FAIL bp_resume: valid=%0b data=%0h want valid=1 data=b", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_clear();
    repeat (2) send_beat(18'd1, 3'd0, 1'b0, 1'b0, 8'd4);
    in_valid = 1'b1; psum_in = 18'd1; clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %0b want 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    repeat (4) send_beat(18'd1, 3'd0, 1'b0, 1'b0, 8'd4);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd4) begin errors++;
      $display("FAIL clear_restart: valid=%0b data=%0h want valid=1 data=4", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_long_group();
    for (int i = 0; i < 254; i++) send_beat(18'd1, 3'd0, 1'b0, 1'b0, 8'hFF);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL long_early: out_valid got %0b want 0", out_valid); end
    send_beat(18'd1, 3'd0, 1'b0, 1'b0, 8'hFF);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd255) begin errors++;
      $display("FAIL long_group: valid=%0b data=%0h want valid=1 data=ff", out_valid, out_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int g = 0; g < 30; g++) begin
          logic [17:0] ps[$];
          logic [2:0]  sh[$];
          logic [7:0]  len = 8'($urandom_range(0, 6));
          bit          sg  = 1'($urandom_range(0, 1));
          bit          sp  = 1'($urandom_range(0, 1));
          int          n   = (len == 0) ? 1 : int'(len);
          for (int b = 0; b < n; b++) begin
            logic [17:0] p = 18'($urandom);
            logic [2:0]  s = 3'($urandom_range(0, 7));
            ps.push_back(p);
            sh.push_back(s);
            if (b == 0) send_beat(p, s, sg, sp, len);
            else        send_beat(p, s, 1'($urandom), 1'($urandom), 8'($urandom));
          end
          exp_q.push_back(model_result(ps, sh, sg, sp));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (!done) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (got_q.size() != exp_q.size()) begin errors++;
      $display("FAIL b2b_count: got %0d results want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++;
          $display("FAIL b2b_result[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    send_beat(18'd3, 3'd0, 1'b0, 1'b0, 8'd3);
    send_beat(18'd4, 3'd0, 1'b0, 1'b0, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin errors++;
      $display("FAIL async_reset: valid=%0b data=%0h want valid=0 data=0", out_valid, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(18'd2, 3'd0, 1'b0, 1'b0, 8'd2);
    send_beat(18'd3, 3'd0, 1'b0, 1'b0, 8'd2);
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd5) begin errors++;
      $display("FAIL async_reset_restart: valid=%0b data=%0h want valid=1 data=5", out_valid, out_data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fused_unsigned();
    test_fused_signed();
    test_split_signed();
    test_shift();
    test_backpressure();
    test_clear();
    test_long_group();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
